// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage of a 5-stage RV32I pipeline. The stage owns the PC
//   register. It builds each 32-bit instruction from four little-endian byte
//   reads on a byte-wide memory port.
//
//   While a fetch is in progress the stage raises stall_if. In DONE it obeys
//   the stall code that the stall controller returns for the PC register.
//   A redirect from EX (jump_en) takes priority in every non-reset state.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   stall_reg_pc  : PC stall code (00 Pass, 01 Hold, 10 Bubb, 11 as Hold)
//   jump_en       : single-cycle redirect request from EX
//   jump_addr     : redirect target; bits [1:0] are forced to zero
//   mem_req       : byte read request
//   mem_addr      : byte address of the current request
//   mem_ready     : mem_rdata is valid for the mem_addr driven this cycle
//   mem_rdata     : returned byte
//   stall_if      : high while a fetch is incomplete (FETCH state)
//   if_valid      : if_inst/if_pc hold a complete instruction
//   if_inst       : assembled instruction
//   if_pc         : address of if_inst
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall_reg_pc,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        stall_if,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] STALL_PASS = 2'b00;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][7:0] byte_q, byte_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            stall_if_q, stall_if_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     jump_target_s;

  // Keep only the address bits the memory actually decodes; the rest read 0.
  function automatic logic [31:0] trunc_addr(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < MEM_ADDR_WIDTH) ? a[i] : 1'b0;
    end
    return r;
  endfunction

  assign jump_target_s = jump_addr & 32'hFFFF_FFFC;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    case (state_q)
      IDLE: begin
        if (jump_en) begin
          pc_d = jump_target_s;
        end else begin
          pc_d = pc_q;
        end
        cnt_d   = 2'd0;
        state_d = FETCH;
      end
      FETCH: begin
        if (jump_en) begin
          // A byte returned in the redirect cycle is discarded.
          pc_d       = jump_target_s;
          cnt_d      = 2'd0;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (mem_ready) begin
          byte_d[cnt_q] = mem_rdata;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d    = DONE;
            if_valid_d = 1'b1;
            if_inst_d  = {mem_rdata, byte_q[2], byte_q[1], byte_q[0]};
            if_pc_d    = pc_q;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      DONE: begin
        if (jump_en) begin
          // The redirect wins over Pass: no pc+4.
          pc_d       = jump_target_s;
          cnt_d      = 2'd0;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (stall_reg_pc == STALL_PASS) begin
          pc_d       = pc_q + 32'd4;
          cnt_d      = 2'd0;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end else begin
          // Hold, Bubb and 2'b11 all hold; the PC register is never bubbled.
          state_d = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        pc_d       = RESET_PC;
        cnt_d      = 2'd0;
        if_valid_d = 1'b0;
      end
    endcase

    // Memory-side outputs are registered from the next state. mem_addr
    // therefore moves only when pc/cnt/state move, and stays put across
    // wait states.
    if (state_d == FETCH) begin
      mem_req_d  = 1'b1;
      stall_if_d = 1'b1;
      mem_addr_d = trunc_addr(pc_d + {30'd0, cnt_d});
    end else begin
      mem_req_d  = 1'b0;
      stall_if_d = 1'b0;
      mem_addr_d = 32'h0000_0000;
    end
  end

  // State and output registers, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      byte_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      stall_if_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'h0000_0000;
      if_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      stall_if_q <= stall_if_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign stall_if = stall_if_q;
  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;

endmodule
